regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single write port among NUM_REQ writeback sources: ALU, load unit and mul/div. Each source uses a valid/ready handshake. The block grants one source per cycle and registers the winning write into the regfile's `load`/`dest`/`in` inputs. It also reports a per-register pending-write mask to hazard logic and keeps a saturating contention counter. It sits between the execute/memory stages and `regfile`.

## Interface
- NUM_REQ, 3, number of writeback sources (2..8); index 0 = ALU, 1 = load unit, 2 = mul/div
- DATA_W, 32, writeback data width
- CNT_W, 16, contention counter width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- hold  in  1  pipeline freeze; blocks all acceptance while high
- req_valid  in  NUM_REQ  source i holds a write
- req_dest  in  NUM_REQ x 5  destination register per source
- req_data  in  NUM_REQ x DATA_W  write data per source
- req_ready  out  NUM_REQ  source i's request is accepted this cycle
- rf_load  out  1  to regfile `load`, registered
- rf_dest  out  5  to regfile `dest`, registered
- rf_in  out  DATA_W  to regfile `in`, registered
- pend_mask  out  32  bit r set while any valid request, or the registered write, targets r≠0
- conflict_cnt  out  CNT_W  saturating count of contended cycles

## Operation
- Handshake: a source holds valid, dest and data stable until it sees `req_ready[i]=1`. Transfer happens when valid && ready in the same cycle. `req_ready` is combinational from the current inputs and arbiter state.
- x0 drop: a valid request with dest==0 is made ready in the same cycle (unless hold) with no write. Any number of x0 drops may be accepted per cycle, alongside one grant.
- Eligible set: sources with valid && dest≠0. When hold=0 and the set is non-empty, exactly one eligible source is granted.
- Grant register: on the next edge, rf_load←1, rf_dest←granted dest, rf_in←granted data. With no grant, rf_load←0 and rf_dest/rf_in keep their old values.
- Priority: a round-robin pointer `ptr` (0..NUM_REQ-1) scans ptr, ptr+1, … mod NUM_REQ. After a grant to index g, ptr←(g+1) mod NUM_REQ. With no grant, ptr is unchanged.
- hold=1: all req_ready=0, no grant, rf_load←0 next edge, ptr frozen. A registered write already on rf_* still completes (it was launched the previous edge).
- Same-dest ordering between different sources is not resolved here; hazard logic uses pend_mask to prevent it.
- pend_mask: OR of one-hot(dest) over valid sources with dest≠0, OR one-hot(rf_dest) when rf_load=1. Combinational.
- conflict_cnt: increments by 1 on each cycle where hold=0 and the eligible set has ≥2 members. Saturates at 2^CNT_W−1.

## Timing
- Accept-to-write latency: 1 cycle. Grant at edge N is applied by regfile at edge N+1; the regfile's internal bypass covers reads in that cycle.
- Throughput: 1 write per cycle.
- Fairness: with all sources continuously eligible, each source waits at most NUM_REQ−1 cycles between grants.
- Reset (rst=1 at edge): ptr=0, rf_load=0, rf_dest=0, rf_in=0, conflict_cnt=0. req_ready is 0 throughout the reset cycle.
- Reset mid-operation: any write launched on rf_* is discarded (rf_load=0 after the edge). Sources must re-present their requests.
- Simultaneous hold and rst: rst wins.

## Configuration
- WB_ARB_RR_EN defined: round-robin priority as described.
- WB_ARB_RR_EN undefined: fixed priority, lowest index wins. The ptr register is removed; fairness is not guaranteed. All other behaviour is identical.

## Test plan
- Reset then idle: rf_load=0, rf_dest=0, conflict_cnt=0, pend_mask=0, req_ready=0 during the reset cycle.
- Single source: src1 valid, dest=5, data=0xDEADBEEF -> req_ready[1]=1 same cycle; next cycle rf_load=1, rf_dest=5, rf_in=0xDEADBEEF; pend_mask bit5 set across both cycles.
- All three valid continuously, dests 1/2/3, RR enabled -> grant order 0,1,2,0,…; conflict_cnt increments every cycle. With the macro off -> src0 granted every cycle.
- x0 drop: src0 dest=0 and src2 dest=7 valid together -> both ready the same cycle; only x7 is written; conflict_cnt unchanged.
- Hold: src1 valid dest=9 with hold=1 for 3 cycles -> req_ready=0, rf_load=0, ptr unchanged; grant in the first cycle after hold drops.
- rst asserted in the cycle after a grant -> rf_load=0 after the edge; the write never appears; ptr=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_REQ writeback sources onto the regfile's single write port.
// Define WB_ARB_RR_EN for round-robin priority; otherwise lowest index wins.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           hold,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][4:0]        req_dest,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rf_load,
    output logic [4:0]                     rf_dest,
    output logic [DATA_W-1:0]              rf_in,
    output logic [31:0]                    pend_mask,
    output logic [CNT_W-1:0]               conflict_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] elig_p0;
    logic [NUM_REQ-1:0] drop_p0;
    logic [PTR_W-1:0]   base_p0;
    logic [PTR_W-1:0]   gnt_idx_p0;
    logic               vld_p0;
    logic               multi_p0;

    // Eligible source nearest to base in circular scan order.
    function automatic logic [PTR_W-1:0] pick(input logic [NUM_REQ-1:0] e,
                                              input logic [PTR_W-1:0]   base);
        logic [PTR_W-1:0] g;
        int best;
        int d;
        g    = '0;
        best = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i >= int'(base)) ? i - int'(base) : i + NUM_REQ - int'(base);
            if (e[i] && d < best) begin
                best = d;
                g    = PTR_W'(i);
            end
        end
        return g;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

`ifdef WB_ARB_RR_EN
    logic [PTR_W-1:0] ptr;

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (vld_p0)
            ptr <= (gnt_idx_p0 == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_p0 + PTR_W'(1);
    end

    assign base_p0 = ptr;
`else
    assign base_p0 = '0;
`endif

    // p0: eligibility, grant selection and handshake
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig_p0[i] = req_valid[i] && (req_dest[i] != 5'd0);
            drop_p0[i] = req_valid[i] && (req_dest[i] == 5'd0);
        end
    end

    assign gnt_idx_p0 = pick(elig_p0, base_p0);
    assign vld_p0     = !rst && !hold && (|elig_p0);
    assign multi_p0   = |(elig_p0 & (elig_p0 - NUM_REQ'(1)));

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = !rst && !hold &&
                           (drop_p0[i] || (vld_p0 && gnt_idx_p0 == PTR_W'(i)));
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (elig_p0[i])
                pend_mask[req_dest[i]] = 1'b1;
        if (rf_load && rf_dest != 5'd0)
            pend_mask[rf_dest] = 1'b1;
    end

    // p1: registered write toward the regfile, contention counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_load      <= 1'b0;
            rf_dest      <= '0;
            rf_in        <= '0;
            conflict_cnt <= '0;
        end else begin
            rf_load <= vld_p0;
            if (vld_p0) begin
                rf_dest <= req_dest[gnt_idx_p0];
                rf_in   <= req_data[gnt_idx_p0];
            end
            if (!hold && multi_p0)
                conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter (NUM_REQ=3, CNT_W=4).
module tb_regfile_wb_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic            hold;
    logic [2:0]      req_valid;
    logic [2:0][4:0] req_dest;
    logic [2:0][31:0] req_data;
    logic [2:0]      req_ready;
    logic            rf_load;
    logic [4:0]      rf_dest;
    logic [31:0]     rf_in;
    logic [31:0]     pend_mask;
    logic [3:0]      conflict_cnt;

`ifdef WB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_dest(req_dest), .req_data(req_data),
        .req_ready(req_ready),
        .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in),
        .pend_mask(pend_mask), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hold;
        logic [2:0]  valid;
        logic [4:0]  d0, d1, d2;
        logic [31:0] x0, x1, x2;
        logic [2:0]  rdy;
        logic [31:0] pend;
        logic        ld;
        logic [4:0]  rdest;
        logic [31:0] rin;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic vec_t mk(logic h, logic [2:0] v,
                                logic [4:0] d0, logic [4:0] d1, logic [4:0] d2,
                                logic [31:0] x0, logic [31:0] x1, logic [31:0] x2,
                                logic [2:0] rdy, logic [31:0] pend, logic ld,
                                logic [4:0] rdest, logic [31:0] rin, logic [3:0] cnt);
        vec_t r;
        r.hold = h; r.valid = v; r.d0 = d0; r.d1 = d1; r.d2 = d2;
        r.x0 = x0; r.x1 = x1; r.x2 = x2; r.rdy = rdy; r.pend = pend;
        r.ld = ld; r.rdest = rdest; r.rin = rin; r.cnt = cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic h, input logic [2:0] v,
                         input logic [4:0] d0, input logic [4:0] d1, input logic [4:0] d2,
                         input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2);
        hold = h;
        req_valid = v;
        req_dest = {d2, d1, d0};
        req_data = {x2, x1, x0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        logic [31:0] p;
        // Vectors applied back to back from a fresh reset (ptr=0, cnt=0).
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b010, 0, 5, 0, 0, 32'hDEADBEEF, 0,
                          3'b010, 32'h20, 1, 5, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0,
                          3'b000, 32'h20, 0, 5, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 3'b101, 0, 0, 7, 32'h11, 0, 32'h77,
                          3'b101, 32'h80, 1, 7, 32'h77, 0));
        for (int k = 0; k < 6; k++) begin
            g = RR ? (k % 3) : 0;
            p = (k == 0) ? 32'h8E : 32'h0E;
            vecs.push_back(mk(0, 3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3,
                              3'(1 << g), p, 1, 5'(g + 1), 32'hA1 + 32'(g), 4'(k + 1)));
        end
        vecs.push_back(mk(1, 3'b010, 0, 9, 0, 0, 32'h99, 0,
                          3'b000, RR ? 32'h208 : 32'h202, 0,
                          RR ? 5'd3 : 5'd1, RR ? 32'hA3 : 32'hA1, 6));
        for (int k = 0; k < 2; k++)
            vecs.push_back(mk(1, 3'b010, 0, 9, 0, 0, 32'h99, 0,
                              3'b000, 32'h200, 0,
                              RR ? 5'd3 : 5'd1, RR ? 32'hA3 : 32'hA1, 6));
        vecs.push_back(mk(0, 3'b010, 0, 9, 0, 0, 32'h99, 0,
                          3'b010, 32'h200, 1, 9, 32'h99, 6));
        vecs.push_back(mk(0, 3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3,
                          RR ? 3'b100 : 3'b001, 32'h20E, 1,
                          RR ? 5'd3 : 5'd1, RR ? 32'hA3 : 32'hA1, 7));
        vecs.push_back(mk(1, 3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3,
                          3'b000, 32'h0E, 0,
                          RR ? 5'd3 : 5'd1, RR ? 32'hA3 : 32'hA1, 7));
        vecs.push_back(mk(0, 3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3,
                          3'b001, 32'h0E, 1, 1, 32'hA1, 8));

        // Reset with idle inputs, then reset with a request present.
        rst = 1'b1;
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        check("reset_rf_load", 32'(rf_load), 32'h0);
        check("reset_rf_dest", 32'(rf_dest), 32'h0);
        check("reset_rf_in", rf_in, 32'h0);
        check("reset_cnt", 32'(conflict_cnt), 32'h0);
        check("reset_pend", pend_mask, 32'h0);
        drive(0, 3'b010, 0, 5, 0, 0, 32'h5, 0);
        #1;
        check("reset_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].hold, vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].d2,
                  vecs[i].x0, vecs[i].x1, vecs[i].x2);
            #1;
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
            check($sformatf("v%0d_pend", i), pend_mask, vecs[i].pend);
            tick();
            check($sformatf("v%0d_rf_load", i), 32'(rf_load), 32'(vecs[i].ld));
            check($sformatf("v%0d_rf_dest", i), 32'(rf_dest), 32'(vecs[i].rdest));
            check($sformatf("v%0d_rf_in", i), rf_in, vecs[i].rin);
            check($sformatf("v%0d_cnt", i), 32'(conflict_cnt), 32'(vecs[i].cnt));
        end

        // Counter saturation: 8 more contended cycles from 8 must stop at 15.
        drive(0, 3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3);
        for (int k = 0; k < 7; k++) tick();
        check("sat_reach", 32'(conflict_cnt), 32'hF);
        tick();
        check("sat_hold", 32'(conflict_cnt), 32'hF);
        tick();
        check("sat_hold2", 32'(conflict_cnt), 32'hF);

        // Reset in the cycle after a grant discards the write and clears ptr.
        drive(0, 3'b010, 0, 6, 0, 0, 32'h66, 0);
        #1;
        check("rg_ready", 32'(req_ready), 32'b010);
        tick();
        check("rg_load", 32'(rf_load), 32'h1);
        check("rg_dest", 32'(rf_dest), 32'h6);
        rst = 1'b1;
        hold = 1'b1;
        drive(1, 3'b001, 2, 0, 0, 32'h22, 0, 0);
        #1;
        check("rg_rst_ready", 32'(req_ready), 32'h0);
        tick();
        check("rg_rst_load", 32'(rf_load), 32'h0);
        check("rg_rst_dest", 32'(rf_dest), 32'h0);
        check("rg_rst_in", rf_in, 32'h0);
        check("rg_rst_cnt", 32'(conflict_cnt), 32'h0);
        rst = 1'b0;
        drive(0, 3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3);
        #1;
        check("rg_ptr_ready", 32'(req_ready), 32'b001);
        tick();
        check("rg_ptr_dest", 32'(rf_dest), 32'h1);
        check("rg_ptr_cnt", 32'(conflict_cnt), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
